// File: rtl/seqparity_pkg.sv
// Shared types and the XOR-reduce helper for the sequential parity engine.
package seqparity_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} seqparity_state_t;

  typedef enum logic {PAR_EVEN = 1'b0, PAR_ODD = 1'b1} parity_mode_e;

  // Widest slice the helper accepts; callers zero-extend narrower slices.
  localparam int unsigned XOR_MAX_W = 1024;

  function automatic logic xor_slice(input logic [XOR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/seqparity_slice.sv
// Combinational M-bit XOR reduce of the low bits of the engine's shift register.
module seqparity_slice
  import seqparity_pkg::*;
#(
  parameter int unsigned M = 4
) (
  input  logic [M-1:0] i_bits,
  output logic         o_par
);

  logic [XOR_MAX_W-1:0] w_ext;

  always_comb begin
    w_ext         = '0;
    w_ext[M-1:0]  = i_bits;
    o_par         = xor_slice(w_ext);
  end

endmodule

// File: rtl/seqparity_engine.sv
// Sequential parity engine: latches an N-bit word and reduces M bits per cycle.
// Optional expected-parity checker enabled by defining SEQPARITY_CHECK_EN.
module seqparity_engine
  import seqparity_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned M = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         odd,
  input  logic [N-1:0] b,
`ifdef SEQPARITY_CHECK_EN
  input  logic         exp_parity,
  output logic         mismatch,
`endif
  output logic         parity,
  output logic         ready,
  output logic         busy,
  output logic         done
);

  localparam int unsigned STEPS = N / M;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if ((M < 1) || (M > N) || ((N % M) != 0) || (M > XOR_MAX_W)) begin : g_bad_params
      $error("seqparity_engine: M must divide N with 1 <= M <= N");
    end
  endgenerate

  seqparity_state_t r_state;
  seqparity_state_t w_state_nxt;
  parity_mode_e     r_mode;
  logic [N-1:0]     r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_acc;
  logic             r_parity;
  logic             r_done;
  logic             w_slice;
  logic             w_load;
  logic             w_finish;
  logic             w_par_final;

  seqparity_slice #(.M(M)) u_slice (
    .i_bits (r_shreg[M-1:0]),
    .o_par  (w_slice)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Final step folds the last slice in directly so the result lands on the same edge.
  assign w_par_final = r_acc ^ w_slice ^ r_mode;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shreg  <= '0;
      r_mode   <= PAR_EVEN;
      r_acc    <= 1'b0;
      r_cnt    <= '0;
      r_parity <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_shreg <= b;
        r_mode  <= parity_mode_e'(odd);
        r_acc   <= 1'b0;
        r_cnt   <= CNT_W'(STEPS - 1);
      end else if (r_state == RUN) begin
        r_acc   <= r_acc ^ w_slice;
        r_shreg <= r_shreg >> M;
        r_cnt   <= r_cnt - CNT_W'(1);
        if (w_finish) r_parity <= w_par_final;
      end
    end
  end

`ifdef SEQPARITY_CHECK_EN
  logic r_exp;
  logic r_mismatch;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_exp      <= 1'b0;
      r_mismatch <= 1'b0;
    end else if (w_load) begin
      r_exp      <= exp_parity;
      r_mismatch <= 1'b0;
    end else if (w_finish) begin
      r_mismatch <= (w_par_final != r_exp);
    end
  end

  assign mismatch = r_mismatch;
`endif

  assign parity = r_parity;
  assign ready  = (r_state == IDLE);
  assign busy   = ~ready;
  assign done   = r_done;

endmodule

// File: tb/tb_seqparity_engine.sv
// Directed bench for seqparity_engine at M = 4, 32, 1, 8 (N = 32); covers SEQPARITY_CHECK_EN when defined.
module tb_seqparity_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start_v;
  logic        odd;
  logic [31:0] b;
  logic [3:0]  done_v, parity_v, ready_v, busy_v;
  logic [3:0]  last_par;
`ifdef SEQPARITY_CHECK_EN
  logic        exp_par;
  logic [3:0]  mismatch_v;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seqparity_engine #(.N(32), .M(4)) u_m4 (
    .clock(clk), .reset_n(rst_n), .start(start_v[0]), .odd(odd), .b(b),
`ifdef SEQPARITY_CHECK_EN
    .exp_parity(exp_par), .mismatch(mismatch_v[0]),
`endif
    .parity(parity_v[0]), .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  seqparity_engine #(.N(32), .M(32)) u_m32 (
    .clock(clk), .reset_n(rst_n), .start(start_v[1]), .odd(odd), .b(b),
`ifdef SEQPARITY_CHECK_EN
    .exp_parity(exp_par), .mismatch(mismatch_v[1]),
`endif
    .parity(parity_v[1]), .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  seqparity_engine #(.N(32), .M(1)) u_m1 (
    .clock(clk), .reset_n(rst_n), .start(start_v[2]), .odd(odd), .b(b),
`ifdef SEQPARITY_CHECK_EN
    .exp_parity(exp_par), .mismatch(mismatch_v[2]),
`endif
    .parity(parity_v[2]), .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  seqparity_engine #(.N(32), .M(8)) u_m8 (
    .clock(clk), .reset_n(rst_n), .start(start_v[3]), .odd(odd), .b(b),
`ifdef SEQPARITY_CHECK_EN
    .exp_parity(exp_par), .mismatch(mismatch_v[3]),
`endif
    .parity(parity_v[3]), .ready(ready_v[3]), .busy(busy_v[3]), .done(done_v[3]));

  typedef struct {
    int          sel;
    logic [31:0] bv;
    logic        od;
    logic        ep;
    logic        expp;
    int          lat;
    int          poke;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // poke >= 0 raises a stray start (b=1) for the edge after observation cycle 'poke'.
  task automatic run_op(input int idx, input vec_t v);
    int  j;
    int  extra;
    bit  seen;
    seen = 0;
    @(negedge clk);
    start_v[v.sel] = 1'b1;
    b   = v.bv;
    odd = v.od;
`ifdef SEQPARITY_CHECK_EN
    exp_par = v.ep;
`endif
    for (j = 0; j <= v.lat + 5; j++) begin
      @(negedge clk);
      start_v[v.sel] = (j == v.poke);
      b   = (j == v.poke) ? 32'h1 : ~v.bv;
      odd = ~v.od;
`ifdef SEQPARITY_CHECK_EN
      exp_par = ~v.ep;
`endif
      if (j == 0) begin
        chk($sformatf("v%0d busy_after_start", idx), 32'(busy_v[v.sel]), 32'd1);
        chk($sformatf("v%0d ready_after_start", idx), 32'(ready_v[v.sel]), 32'd0);
        chk($sformatf("v%0d parity_hold", idx), 32'(parity_v[v.sel]), 32'(last_par[v.sel]));
`ifdef SEQPARITY_CHECK_EN
        chk($sformatf("v%0d mismatch_cleared", idx), 32'(mismatch_v[v.sel]), 32'd0);
`endif
      end
      if (done_v[v.sel]) begin
        seen = 1;
        break;
      end
    end
    start_v[v.sel] = 1'b0;
    chk($sformatf("v%0d done_seen", idx), 32'(seen), 32'd1);
    chk($sformatf("v%0d latency", idx), 32'(j), 32'(v.lat));
    chk($sformatf("v%0d parity", idx), 32'(parity_v[v.sel]), 32'(v.expp));
    chk($sformatf("v%0d ready_at_done", idx), 32'(ready_v[v.sel]), 32'd1);
`ifdef SEQPARITY_CHECK_EN
    chk($sformatf("v%0d mismatch", idx), 32'(mismatch_v[v.sel]), 32'(v.expp != v.ep));
`endif
    last_par[v.sel] = v.expp;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_v[v.sel]) extra++;
    end
    chk($sformatf("v%0d no_extra_done", idx), 32'(extra), 32'd0);
    chk($sformatf("v%0d ready_idle", idx), 32'(ready_v[v.sel]), 32'd1);
  endtask

  initial begin
    int pulses;
    int prev;
    int extra;

    rst_n    = 1'b0;
    start_v  = '0;
    odd      = 1'b0;
    b        = '0;
    last_par = '0;
`ifdef SEQPARITY_CHECK_EN
    exp_par  = 1'b0;
`endif

    //        sel  b              odd  ep   par  lat poke
    tbl.push_back('{1, 32'h8000_0001, 1'b0, 1'b0, 1'b0,  1, -1});
    tbl.push_back('{2, 32'h8000_0001, 1'b0, 1'b0, 1'b0, 32, -1});
    tbl.push_back('{3, 32'h8000_0001, 1'b0, 1'b0, 1'b0,  4, -1});
    tbl.push_back('{2, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 32, -1});
    tbl.push_back('{1, 32'h0000_0003, 1'b1, 1'b1, 1'b1,  1, -1});
    tbl.push_back('{3, 32'h0000_0007, 1'b1, 1'b0, 1'b0,  4, -1});
    tbl.push_back('{0, 32'h0000_0001, 1'b1, 1'b0, 1'b0,  8, -1});
    tbl.push_back('{0, 32'h0000_0001, 1'b0, 1'b1, 1'b1,  8, -1});
    tbl.push_back('{0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1,  8,  2});
    tbl.push_back('{0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0,  8,  7});
    tbl.push_back('{0, 32'h0000_0003, 1'b1, 1'b0, 1'b1,  8, -1});
    tbl.push_back('{0, 32'h0000_0003, 1'b1, 1'b1, 1'b1,  8, -1});
    tbl.push_back('{0, 32'h1234_5678, 1'b0, 1'b1, 1'b1,  8, -1});

    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("reset_ready%0d", s), 32'(ready_v[s]), 32'd1);
      chk($sformatf("reset_busy%0d", s), 32'(busy_v[s]), 32'd0);
      chk($sformatf("reset_parity%0d", s), 32'(parity_v[s]), 32'd0);
      chk($sformatf("reset_done%0d", s), 32'(done_v[s]), 32'd0);
    end
    rst_n = 1'b1;

    foreach (tbl[i]) run_op(i, tbl[i]);

    // Back-to-back with start held high: one result every STEPS+1 = 9 cycles.
    @(negedge clk);
    start_v[0] = 1'b1;
    b      = 32'hA5A5_A5A5;
    odd    = 1'b1;
    pulses = 0;
    prev   = -1;
    for (int c = 0; c < 60 && pulses < 3; c++) begin
      @(negedge clk);
      if (done_v[0]) begin
        chk($sformatf("b2b_parity%0d", pulses), 32'(parity_v[0]), 32'd1);
        if (prev >= 0) chk($sformatf("b2b_spacing%0d", pulses), 32'(c - prev), 32'd9);
        prev = c;
        pulses++;
      end
    end
    start_v[0] = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd3);
    last_par[0] = 1'b1;
    @(negedge clk);
    chk("b2b_ready_after", 32'(ready_v[0]), 32'd1);

    // Asynchronous abort mid-operation; previous result (1) must be wiped.
    @(negedge clk);
    start_v[0] = 1'b1;
    b   = 32'hFFFF_0000;
    odd = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("abort_busy_before", 32'(busy_v[0]), 32'd1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready_v[0]), 32'd1);
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    chk("abort_parity", 32'(parity_v[0]), 32'd0);
    chk("abort_done", 32'(done_v[0]), 32'd0);
`ifdef SEQPARITY_CHECK_EN
    chk("abort_mismatch", 32'(mismatch_v[0]), 32'd0);
`endif
    last_par = '0;
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) extra++;
    end
    chk("abort_no_done", 32'(extra), 32'd0);
    chk("abort_ready_after", 32'(ready_v[0]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
